ifetch_q: RTL and testbench

Instruction prefetch queue sitting directly upstream of the `sisc` core. It issues sequential word fetches to instruction memory over a request/acknowledge handshake, buffers returned instruction words with their addresses in a small FIFO, and presents them to the core's `ir` input under a valid/ready handshake. A redirect input (branch taken) flushes the queue, discards any stale in-flight fetch, and restarts fetching at a new address.

---
 rtl/ifetch_q.sv | 152 +++++++++++++++
 tb/tb_ifetch_q.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_q.sv
// ifetch_q: sequential instruction prefetch queue feeding the sisc core.
// Issues one word fetch at a time, buffers {pc, word} pairs in a small FIFO,
// and flushes and restarts on a branch redirect. All outputs are registered.
module ifetch_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  output logic          im_req,
  output logic [AW-1:0] im_addr,
  input  logic          im_ack,
  input  logic [31:0]   im_data,
  output logic [31:0]   ir_out,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] fetch_pc_inc;
  logic [31:0]   word_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          pop, push;
  logic [PW-1:0] head_nx, tail_nx;
  logic [CW-1:0] count_nx;
  logic [31:0]   out_nx;
  logic [AW-1:0] pc_nx;

  // Next FIFO bookkeeping and next head entry; redirect overrides push and pop.
  // The output registers are loaded from the post-edge head, so a word pushed
  // into an otherwise empty queue is forwarded straight from the memory bus.
  always_comb begin
    pop          = ir_valid && ir_ready;
    push         = (state == S_WAIT) && im_ack && !redirect;
    fetch_pc_inc = fetch_pc + AW'(1);
    head_nx      = head;
    tail_nx      = tail;
    count_nx     = count;
    out_nx       = '0;
    pc_nx        = '0;
    if (redirect) begin
      head_nx  = '0;
      tail_nx  = '0;
      count_nx = '0;
    end else begin
      head_nx  = head + PW'(pop);
      tail_nx  = tail + PW'(push);
      count_nx = count + CW'(push) - CW'(pop);
      if (count_nx != '0) begin
        if (push && count_nx == CW'(1)) begin
          out_nx = im_data;
          pc_nx  = fetch_pc;
        end else begin
          out_nx = word_mem[head_nx];
          pc_nx  = pc_mem[head_nx];
        end
      end
    end
  end

  // FIFO storage write on push.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[tail] <= im_data;
      pc_mem[tail]   <= fetch_pc;
    end
  end

  // Fetch FSM, queue pointers and registered core-side outputs.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= S_IDLE;
      fetch_pc <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      im_req   <= 1'b0;
      im_addr  <= '0;
      ir_valid <= 1'b0;
      ir_out   <= '0;
      ir_pc    <= '0;
    end else begin
      head     <= head_nx;
      tail     <= tail_nx;
      count    <= count_nx;
      ir_valid <= (count_nx != '0);
      ir_out   <= out_nx;
      ir_pc    <= pc_nx;
      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_addr;
          end else if (count < FULL) begin
            im_req  <= 1'b1;
            im_addr <= fetch_pc;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_addr;
            if (im_ack) begin
              im_req <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state  <= S_DRAIN;
            end
          end else if (im_ack) begin
            fetch_pc <= fetch_pc_inc;
            if (count_nx < FULL) begin
              im_addr <= fetch_pc_inc;
            end else begin
              im_req <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            fetch_pc <= redirect_addr;
          end
          if (im_ack) begin
            im_req <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          im_req <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_q.sv
// Testbench for ifetch_q: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ifetch_q;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 16;

  logic          clk;
  logic          rst_f;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [31:0]   im_data;
  logic [31:0]   ir_out;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;

  int checks = 0;
  int errors = 0;

  ifetch_q #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_f(rst_f),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_data(im_data),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_addr(redirect_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = 0xA000_0000 + addr, ack after 'lat' wait cycles.
  int unsigned lat;
  int unsigned lat_cnt;
  assign im_ack  = im_req && (lat_cnt >= lat);
  assign im_data = im_ack ? (32'hA000_0000 + {16'h0, im_addr}) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) lat_cnt <= 0;
    else if (im_req && !im_ack) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, word}, an outstanding-request flag and a
  // stale flag for a request whose data must be thrown away.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fpc;
  logic [15:0] m_addr;
  bit          m_out;
  bit          m_stale;

  always @(posedge clk or negedge rst_f) begin
    bit pop_ok;
    bit room;
    if (!rst_f) begin
      mq.delete();
      m_fpc = '0; m_addr = '0; m_out = 0; m_stale = 0;
    end else begin
      pop_ok = (mq.size() != 0) && ir_ready;
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_addr;
        if (m_out && im_ack) begin
          m_out = 0; m_stale = 0;
        end else if (m_out) begin
          m_stale = 1;
        end
      end else begin
        room = mq.size() < DEPTH;
        if (pop_ok) void'(mq.pop_front());
        if (!m_out) begin
          if (room) begin
            m_out = 1; m_addr = m_fpc;
          end
        end else if (im_ack) begin
          if (m_stale) begin
            m_out = 0; m_stale = 0;
          end else begin
            mq.push_back({m_fpc, 32'hA000_0000 + {16'h0, m_fpc}});
            m_fpc = m_fpc + 16'd1;
            if (mq.size() < DEPTH) m_addr = m_fpc;
            else m_out = 0;
          end
        end
      end
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    chk("im_req", {31'h0, im_req}, {31'h0, m_out});
    if (m_out) chk("im_addr", {16'h0, im_addr}, {16'h0, m_addr});
    chk("ir_valid", {31'h0, ir_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
    chk("ir_pc", {16'h0, ir_pc}, (mq.size() != 0) ? {16'h0, mq[0].pc} : 32'h0);
    chk("ir_out", ir_out, (mq.size() != 0) ? mq[0].w : 32'h0);
  end

  // Logs of consumed pcs and acknowledged fetch addresses.
  logic [15:0] cons_log[$];
  logic [15:0] ack_log[$];

  always @(posedge clk) begin
    if (rst_f && ir_valid && ir_ready) cons_log.push_back(ir_pc);
    if (rst_f && im_req && im_ack) ack_log.push_back(im_addr);
  end

  function automatic logic [31:0] cons_at(input int i);
    return (i < cons_log.size()) ? {16'h0, cons_log[i]} : 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (i < ack_log.size()) ? {16'h0, ack_log[i]} : 32'hDEAD_0000;
  endfunction

  task automatic clear_logs();
    cons_log.delete();
    ack_log.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_im_req"}, {31'h0, im_req}, 32'h0);
    chk({tag, "_im_addr"}, {16'h0, im_addr}, 32'h0);
    chk({tag, "_ir_valid"}, {31'h0, ir_valid}, 32'h0);
    chk({tag, "_ir_out"}, ir_out, 32'h0);
    chk({tag, "_ir_pc"}, {16'h0, ir_pc}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_f = 1'b0;
    clear_logs();
    @(posedge clk); #2;
    rst_f = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [15:0] addr);
    redirect = 1'b1; redirect_addr = addr;
    @(posedge clk); #1;
    clear_logs();
    #1;
    redirect = 1'b0;
  endtask

  logic [15:0] exp_wrap[4];
  bit found;

  initial begin
    exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    rst_f = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = '0; lat = 0;
    #1;
    chk_zero_outputs("reset");

    // Zero-wait streaming from address 0
    repeat (2) @(posedge clk);
    #2 rst_f = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'h0, im_req}, 32'd1);
    chk("first_addr", {16'h0, im_addr}, 32'h0);
    @(posedge clk); #1;
    chk("first_valid", {31'h0, ir_valid}, 32'd1);
    chk("first_word", ir_out, 32'hA000_0000);
    chk("first_pc", {16'h0, ir_pc}, 32'h0);
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) chk("stream_pc", cons_at(i), i);

    // Core stalled: exactly DEPTH fetches, then hold
    ir_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("stall_fetches", ack_log.size(), 32'd4);
    chk("stall_req", {31'h0, im_req}, 32'h0);
    chk("stall_pc", {16'h0, ir_pc}, 32'h0);
    chk("stall_word", ir_out, 32'hA000_0000);
    #1 ir_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) chk("drain_pc", cons_at(i), i);

    // Redirect while the addr-5 request waits on a slow memory
    lat = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (im_req && im_addr == 16'd5 && !im_ack) found = 1;
    end
    chk("wait_addr5", {31'h0, found}, 32'd1);
    pulse_redirect(16'h0040);
    chk("drain_req_held", {31'h0, im_req}, 32'd1);
    chk("drain_addr_held", {16'h0, im_addr}, 32'd5);
    chk("drain_valid", {31'h0, ir_valid}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("stale_ack", ack_at(0), 32'h5);
    chk("redir_fetch", ack_at(1), 32'h40);
    chk("redir_pc", cons_at(0), 32'h40);

    // Redirect coinciding with ack and pop on a zero-wait memory
    lat = 0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (im_ack && ir_valid) found = 1;
    end
    chk("wait_steady", {31'h0, found}, 32'd1);
    pulse_redirect(16'h0010);
    chk("ack_redir_valid", {31'h0, ir_valid}, 32'h0);
    chk("ack_redir_req", {31'h0, im_req}, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    chk("ack_redir_fetch", ack_at(0), 32'h10);
    chk("ack_redir_pc", cons_at(0), 32'h10);

    // Address wrap
    @(negedge clk);
    pulse_redirect(16'hFFFE);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("wrap_pc", cons_at(i), {16'h0, exp_wrap[i]});

    // Asynchronous reset while a request is outstanding on a filling queue
    lat = 5;
    ir_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (im_req && ir_valid && !im_ack) found = 1;
    end
    chk("wait_midreq", {31'h0, found}, 32'd1);
    @(posedge clk); #3;
    rst_f = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    lat = 0; ir_ready = 1'b1;
    clear_logs();
    @(posedge clk); #2;
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", {31'h0, im_req}, 32'd1);
    chk("restart_addr", {16'h0, im_addr}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("restart_pc", cons_at(0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
